bcd_score_display: RTL and testbench

Parametrised multi-digit BCD score register with an on-screen 7-segment renderer. It holds an NDIGITS decimal score. A valid/ready port adds one BCD digit at any digit position, and the carry ripples serially, one digit per clock. The block also renders the score as scaled 5x5 segment glyphs for the video path. It sits beside the hvsync generator and takes hpos/vpos/display_on directly; game logic drives the add port.

---
 rtl/bcd_score_display_if.sv | 10 +
 rtl/bcd_score_display.sv | 236 +++++++++++++++++++++++
 tb/tb_bcd_score_display.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_score_display_if.sv
// Add-request handshake between game logic (master) and the BCD score register (slave).
interface bcd_score_display_if;
  logic       add_valid;
  logic       add_ready;
  logic [3:0] add_value;
  logic [2:0] add_pos;

  modport master (output add_valid, output add_value, output add_pos, input add_ready);
  modport slave  (input add_valid, input add_value, input add_pos, output add_ready);
endinterface

// File: rtl/bcd_score_display.sv
// Multi-digit BCD score register with serial ripple-carry adder and a
// 2-stage 7-segment glyph renderer for the video path.
module bcd_score_display #(
  parameter int NDIGITS    = 4,
  parameter int SCALE_LOG2 = 1,
  parameter int X0         = 0,
  parameter int Y0         = 0,
  parameter bit SATURATE   = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8:0]             hpos,
  input  logic [8:0]             vpos,
  input  logic                   display_on,
  bcd_score_display_if.slave     add_if,
  input  logic                   clear,
  output logic [4*NDIGITS-1:0]   score,
  output logic                   overflow,
  output logic                   pixel,
  output logic                   pixel_valid
);
  localparam int          CELL = 8 << SCALE_LOG2;
  localparam logic [3:0]  ND   = 4'(NDIGITS);
  localparam logic [11:0] XLO  = 12'(X0);
  localparam logic [11:0] XHI  = 12'(X0 + NDIGITS * CELL);
  localparam logic [11:0] YLO  = 12'(Y0);
  localparam logic [11:0] YHI  = 12'(Y0 + CELL);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ADD = 1'b1} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Segments a..g map to seg[6:0]; only x in 0..4 is meaningful to callers.
  function automatic logic glyph_bit(input logic [6:0] seg, input logic [2:0] x,
                                     input logic [2:0] y);
    logic l, r;
    l = (x == 3'd0);
    r = (x == 3'd4);
    case (y)
      3'd0:    glyph_bit = seg[6] | (l & seg[1]) | (r & seg[5]);
      3'd1:    glyph_bit = (l & seg[1]) | (r & seg[5]);
      3'd2:    glyph_bit = seg[0] | (l & (seg[1] | seg[2])) | (r & (seg[5] | seg[4]));
      3'd3:    glyph_bit = (l & seg[2]) | (r & seg[4]);
      3'd4:    glyph_bit = seg[3] | (l & seg[2]) | (r & seg[4]);
      default: glyph_bit = 1'b0;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [3:0] dig_q [NDIGITS];
  logic [3:0] dig_d [NDIGITS];
  logic [3:0] carry_q, carry_d;
  logic [3:0] k_q, k_d;
  logic       overflow_q, overflow_d;
  logic [3:0] cur_dig_s;
  logic [4:0] sum_s;
  logic [3:0] new_dig_s;
  logic       carry_out_s;
  logic       req_ok_s;

  assign add_if.add_ready = (state_q == S_IDLE) && !clear;
  assign overflow         = overflow_q;

  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_score
    assign score[4*gi +: 4] = dig_q[gi];
  end

  // Digit under the adder cursor and its sum with the pending carry.
  always_comb begin
    cur_dig_s = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      cur_dig_s = (k_q == 4'(i)) ? dig_q[i] : cur_dig_s;
    end
    sum_s       = {1'b0, cur_dig_s} + {1'b0, carry_q};
    carry_out_s = (sum_s >= 5'd10);
    new_dig_s   = carry_out_s ? 4'(sum_s - 5'd10) : sum_s[3:0];
    req_ok_s    = (add_if.add_value <= 4'd9) && ({1'b0, add_if.add_pos} < ND);
  end

  // Add FSM next state; clear overrides everything.
  always_comb begin
    state_d    = state_q;
    carry_d    = carry_q;
    k_d        = k_q;
    overflow_d = overflow_q;
    for (int i = 0; i < NDIGITS; i++) begin
      dig_d[i] = dig_q[i];
    end
    if (clear) begin
      state_d    = S_IDLE;
      carry_d    = 4'd0;
      k_d        = 4'd0;
      overflow_d = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
        dig_d[i] = 4'd0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (add_if.add_valid && req_ok_s) begin
            carry_d = add_if.add_value;
            k_d     = {1'b0, add_if.add_pos};
            state_d = S_ADD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADD: begin
          for (int i = 0; i < NDIGITS; i++) begin
            dig_d[i] = (k_q == 4'(i)) ? new_dig_s : dig_q[i];
          end
          carry_d = {3'd0, carry_out_s};
          k_d     = k_q + 4'd1;
          if (!carry_out_s) begin
            state_d = S_IDLE;
          end else if (k_q == ND - 4'd1) begin
            // Carry out of the top digit: flag it and optionally pin at all-9s.
            overflow_d = 1'b1;
            state_d    = S_IDLE;
            for (int i = 0; i < NDIGITS; i++) begin
              dig_d[i] = SATURATE ? 4'd9 : dig_d[i];
            end
          end else begin
            state_d = S_ADD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Score and adder state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      carry_q    <= 4'd0;
      k_q        <= 4'd0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
        dig_q[i] <= 4'd0;
      end
    end else begin
      state_q    <= state_d;
      carry_q    <= carry_d;
      k_q        <= k_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < NDIGITS; i++) begin
        dig_q[i] <= dig_d[i];
      end
    end
  end

  logic [11:0] hx_s, vy_s;
  logic        inr_d, inr_q;
  logic [2:0]  cell_d, cell_q, x_d, x_q, y_d, y_q;
  logic        de1_q;
  logic [NDIGITS-1:0] blank_s;
  logic [3:0]  sel_dig_s;
  logic        sel_blank_s;
  logic        pixel_d, pixel_q, pixel_valid_q;

  // Stage 1: cell index and cell-local glyph coordinates.
  always_comb begin
    hx_s   = {3'd0, hpos} - XLO;
    vy_s   = {3'd0, vpos} - YLO;
    inr_d  = ({3'd0, hpos} >= XLO) && ({3'd0, hpos} < XHI) &&
             ({3'd0, vpos} >= YLO) && ({3'd0, vpos} < YHI);
    cell_d = 3'(hx_s >> (3 + SCALE_LOG2));
    x_d    = 3'(hx_s >> SCALE_LOG2);
    y_d    = 3'(vy_s >> SCALE_LOG2);
  end

  // A digit is blank when it and everything above it are zero; digit 0 always shows.
  always_comb begin
    logic acc;
    blank_s = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      acc = 1'b1;
      for (int j = 0; j < NDIGITS; j++) begin
        acc = acc & ((j < i) || (dig_q[j] == 4'd0));
      end
      blank_s[i] = BLANK_LZ & (i != 0) & acc;
    end
  end

  // Stage 2: pick the live digit for the cell and decode its glyph bit.
  always_comb begin
    sel_dig_s   = 4'd0;
    sel_blank_s = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      sel_dig_s   = (cell_q == 3'(NDIGITS - 1 - i)) ? dig_q[i]   : sel_dig_s;
      sel_blank_s = (cell_q == 3'(NDIGITS - 1 - i)) ? blank_s[i] : sel_blank_s;
    end
    pixel_d = de1_q & inr_q & (x_q < 3'd5) & (y_q < 3'd5) & ~sel_blank_s &
              glyph_bit(seg7(sel_dig_s), x_q, y_q);
  end

  // Render pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inr_q         <= 1'b0;
      cell_q        <= 3'd0;
      x_q           <= 3'd0;
      y_q           <= 3'd0;
      de1_q         <= 1'b0;
      pixel_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
    end else begin
      inr_q         <= inr_d;
      cell_q        <= cell_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de1_q         <= display_on;
      pixel_q       <= pixel_d;
      pixel_valid_q <= de1_q;
    end
  end

  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
endmodule

// File: tb/tb_bcd_score_display.sv
// Bench for bcd_score_display: a saturating and a wrapping instance share stimulus
// and are compared every cycle against a decimal-arithmetic model of score and glyphs.
module tb_bcd_score_display;
  localparam int N = 4;
  localparam int S = 1;
  localparam int C = 8 << S;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  hpos, vpos;
  logic        display_on, clear;
  logic        add_valid;
  logic [3:0]  add_value;
  logic [2:0]  add_pos;
  logic [15:0] score0, score1;
  logic        ovf0, ovf1, pix0, pix1, pv0, pv1, rdy0, rdy1;

  bcd_score_display_if if0 ();
  bcd_score_display_if if1 ();
  assign if0.add_valid = add_valid;
  assign if0.add_value = add_value;
  assign if0.add_pos   = add_pos;
  assign if1.add_valid = add_valid;
  assign if1.add_value = add_value;
  assign if1.add_pos   = add_pos;
  assign rdy0 = if0.add_ready;
  assign rdy1 = if1.add_ready;

  bcd_score_display #(.NDIGITS(N), .SCALE_LOG2(S), .X0(0), .Y0(0), .SATURATE(1'b1), .BLANK_LZ(1'b1))
  dut0 (.clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .add_if(if0.slave), .clear(clear), .score(score0), .overflow(ovf0),
        .pixel(pix0), .pixel_valid(pv0));

  bcd_score_display #(.NDIGITS(N), .SCALE_LOG2(S), .X0(0), .Y0(0), .SATURATE(1'b0), .BLANK_LZ(1'b1))
  dut1 (.clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .add_if(if1.slave), .clear(clear), .score(score1), .overflow(ovf1),
        .pixel(pix1), .pixel_valid(pv1));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bit [6:0] SEG [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                         7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = 16'h0000;
    int t = v;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Sum of the original low part and the addend, looking at positions below p+j.
  function automatic int tot_at(input int old, input int v, input int p, input int j);
    return (old % pow10(p + j)) + v * pow10(p);
  endfunction

  function automatic int hi_part(input int old, input int lvl);
    return old - (old % pow10(lvl));
  endfunction

  // Geometric glyph: horizontal bars a/g/d on rows 0/2/4, verticals span half-heights.
  function automatic bit model_pixel(input int sc, input int h, input int v);
    int i, x, y, dix, dv;
    bit [6:0] sg;
    if (h >= N * C || v >= C) return 1'b0;
    i = h / C;
    x = (h - i * C) / (1 << S);
    y = v / (1 << S);
    if (x >= 5 || y >= 5) return 1'b0;
    dix = N - 1 - i;
    if (dix > 0 && (sc / pow10(dix)) == 0) return 1'b0;
    dv = (sc / pow10(dix)) % 10;
    sg = SEG[dv];
    if ((y == 0 && sg[6]) || (y == 2 && sg[0]) || (y == 4 && sg[3])) return 1'b1;
    if (x == 0 && ((y <= 2 && sg[1]) || (y >= 2 && sg[2]))) return 1'b1;
    if (x == 4 && ((y <= 2 && sg[5]) || (y >= 2 && sg[4]))) return 1'b1;
    return 1'b0;
  endfunction

  int m_score [2];
  int m_old [2];
  int m_v [2];
  int m_p [2];
  int m_j [2];
  bit m_busy [2];
  bit m_ovf [2];
  bit m_pix [2];
  bit m_pv [2];
  int h1, v1;
  bit de1;

  // Reference model: instance 0 saturates, instance 1 wraps.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        m_score[m] <= 0; m_busy[m] <= 1'b0; m_ovf[m] <= 1'b0;
        m_pix[m] <= 1'b0; m_pv[m] <= 1'b0; m_j[m] <= 0;
      end
      h1 <= 0; v1 <= 0; de1 <= 1'b0;
    end else begin
      h1 <= int'(hpos); v1 <= int'(vpos); de1 <= display_on;
      for (int m = 0; m < 2; m++) begin
        m_pix[m] <= de1 && model_pixel(m_score[m], h1, v1);
        m_pv[m]  <= de1;
        if (clear) begin
          m_score[m] <= 0; m_ovf[m] <= 1'b0; m_busy[m] <= 1'b0;
        end else if (m_busy[m]) begin
          m_j[m] <= m_j[m] + 1;
          if (tot_at(m_old[m], m_v[m], m_p[m], m_j[m] + 1) < pow10(m_p[m] + m_j[m] + 1)) begin
            m_score[m] <= hi_part(m_old[m], m_p[m] + m_j[m] + 1) +
                          tot_at(m_old[m], m_v[m], m_p[m], m_j[m] + 1);
            m_busy[m]  <= 1'b0;
          end else if (m_p[m] + m_j[m] + 1 == N) begin
            m_ovf[m]   <= 1'b1;
            m_busy[m]  <= 1'b0;
            m_score[m] <= (m == 0) ? pow10(N) - 1
                                   : tot_at(m_old[m], m_v[m], m_p[m], m_j[m] + 1) - pow10(N);
          end else begin
            m_score[m] <= hi_part(m_old[m], m_p[m] + m_j[m] + 1) +
                          tot_at(m_old[m], m_v[m], m_p[m], m_j[m] + 1) - pow10(m_p[m] + m_j[m] + 1);
          end
        end else if (add_valid && add_value <= 4'd9 && int'(add_pos) < N) begin
          m_busy[m] <= 1'b1; m_old[m] <= m_score[m]; m_v[m] <= int'(add_value);
          m_p[m] <= int'(add_pos); m_j[m] <= 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("score_sat",  32'(score0), 32'(to_bcd(m_score[0])));
      check("score_wrap", 32'(score1), 32'(to_bcd(m_score[1])));
      check("ovf_sat",    32'(ovf0),   32'(m_ovf[0]));
      check("ovf_wrap",   32'(ovf1),   32'(m_ovf[1]));
      check("ready_sat",  32'(rdy0),   32'(!m_busy[0] && !clear));
      check("ready_wrap", 32'(rdy1),   32'(!m_busy[1] && !clear));
      check("pixel_sat",  32'(pix0),   32'(m_pix[0]));
      check("pixel_wrap", 32'(pix1),   32'(m_pix[1]));
      check("pvalid_sat", 32'(pv0),    32'(m_pv[0]));
      check("pvalid_wrap",32'(pv1),    32'(m_pv[1]));
    end
  end

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: ready not seen within bound at %0t", name, $time);
  endtask

  task automatic do_add(input int v, input int p);
    int t;
    @(posedge clk); #1;
    add_valid = 1'b1; add_value = 4'(v); add_pos = 3'(p);
    t = 0;
    @(negedge clk);
    while (!rdy0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) timeout_fail("add_timeout");
    @(posedge clk); #1;
    add_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (!(rdy0 && rdy1) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) timeout_fail("idle_timeout");
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic set_score(input int d3, input int d2, input int d1, input int d0);
    pulse_clear();
    if (d3 != 0) begin do_add(d3, 3); wait_idle(); end
    if (d2 != 0) begin do_add(d2, 2); wait_idle(); end
    if (d1 != 0) begin do_add(d1, 1); wait_idle(); end
    if (d0 != 0) begin do_add(d0, 0); wait_idle(); end
  endtask

  task automatic sweep(output int lit);
    lit = 0;
    @(posedge clk); #1 display_on = 1'b0;
    repeat (3) @(posedge clk);
    for (int v = 0; v < C; v++) begin
      for (int h = 0; h < N * C; h++) begin
        @(posedge clk); #1;
        hpos = 9'(h); vpos = 9'(v); display_on = 1'b1;
        @(negedge clk);
        lit = lit + int'(pix0 & pv0);
      end
    end
    @(posedge clk); #1 display_on = 1'b0;
    repeat (3) begin
      @(negedge clk);
      lit = lit + int'(pix0 & pv0);
    end
  endtask

  initial begin
    int lit, lowcnt;
    reset = 1'b0; clear = 1'b0; add_valid = 1'b0; add_value = 4'd0; add_pos = 3'd0;
    hpos = 9'd0; vpos = 9'd0; display_on = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("reset_score", 32'(score0), 32'h0);
    check("reset_ovf",   32'(ovf0),   32'h0);
    check("reset_ready", 32'(rdy0),   32'h1);
    check("reset_pixel", 32'(pix0),   32'h0);
    sweep(lit);
    check("reset_lit_zero_glyph", 32'(lit), 32'd64);

    // Ripple carry 0999 + 1.
    set_score(0, 9, 9, 9);
    do_add(1, 0);
    lowcnt = 0;
    @(negedge clk);
    while (!rdy0 && lowcnt < 20) begin
      lowcnt++;
      @(negedge clk);
    end
    check("ripple_busy_cycles", 32'(lowcnt), 32'd4);
    check("ripple_score", 32'(score0), 32'h1000);
    check("ripple_ovf",   32'(ovf0),   32'h0);

    // Overflow in both flavours from 9999 + 5.
    set_score(9, 9, 9, 9);
    do_add(5, 0);
    wait_idle();
    check("ovf_sat_score",  32'(score0), 32'h9999);
    check("ovf_sat_flag",   32'(ovf0),   32'h1);
    check("ovf_wrap_score", 32'(score1), 32'h0004);
    check("ovf_wrap_flag",  32'(ovf1),   32'h1);

    // Out-of-range value is consumed without effect.
    do_add(12, 0);
    @(negedge clk);
    check("invalid_ready", 32'(rdy0),   32'h1);
    check("invalid_score", 32'(score0), 32'h9999);

    // Clear during an ADD with a competing request.
    do_add(1, 0);
    @(posedge clk); #1;
    clear = 1'b1; add_valid = 1'b1; add_value = 4'd3; add_pos = 3'd0;
    @(negedge clk);
    check("clear_ready_low", 32'(rdy0), 32'h0);
    @(posedge clk); #1;
    clear = 1'b0; add_valid = 1'b0;
    @(negedge clk);
    check("clear_score", 32'(score0), 32'h0);
    check("clear_ovf",   32'(ovf0),   32'h0);
    check("clear_ready", 32'(rdy0),   32'h1);

    // Render sweeps.
    set_score(0, 0, 0, 8);
    sweep(lit);
    check("render_0008_lit", 32'(lit), 32'd76);
    set_score(1, 2, 3, 4);
    sweep(lit);
    check("render_1234_lit", 32'(lit), 32'd200);

    // Asynchronous reset in the middle of a ripple.
    set_score(0, 9, 9, 9);
    do_add(1, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1;
    check("async_reset_score", 32'(score0), 32'h0);
    check("async_reset_pixel", 32'(pix0),   32'h0);
    @(posedge clk); #1 reset = 1'b1;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      add_valid  = ($urandom_range(0, 2) == 0);
      add_value  = 4'($urandom_range(0, 11));
      add_pos    = 3'($urandom_range(0, 7));
      clear      = ($urandom_range(0, 63) == 0);
      hpos       = 9'($urandom_range(0, 79));
      vpos       = 9'($urandom_range(0, 19));
      display_on = ($urandom_range(0, 7) != 0);
    end
    @(posedge clk); #1;
    add_valid = 1'b0; clear = 1'b0; display_on = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
